// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI command decoder / register bank:
// FSM encoding, command byte bit positions and the default idle byte.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        S_CMD = 2'd0,
        S_WR  = 2'd1,
        S_RD  = 2'd2,
        S_IGN = 2'd3
    } state_t;

    localparam int CMD_W_BIT    = 7;
    localparam int CMD_AI_BIT   = 6;
    localparam int CMD_RSVD_BIT = 5;

    localparam logic [7:0] DEF_IDLE_BYTE = 8'hA5;

endpackage

// File: rtl/spi_cs_sync.sv
// Brings the raw SPI chip select into the system clock domain and flags its
// rising edge (end of transaction) with a registered one-cycle pulse.
module spi_cs_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs_n,
    output logic cs_sync,
    output logic cs_rise
);

    logic sync1, sync2, sync2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync2_d <= 1'b1;
            cs_rise <= 1'b0;
        end else begin
            sync1   <= cs_n;
            sync2   <= sync1;
            sync2_d <= sync2;
            cs_rise <= sync2 & ~sync2_d;
        end
    end

    assign cs_sync = sync2;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command decoder and register bank behind an SPI slave: parses a command
// byte plus data bytes, writes/reads an 8-bit register array, feeds TX.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] IDLE_BYTE = DEF_IDLE_BYTE,
    localparam int        DEPTH     = 2 ** ADDR_W
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    input  logic                 i_RX_DV,
    input  logic [7:0]           i_RX_Byte,
    input  logic                 i_SPI_CS_n,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    output logic [8*DEPTH-1:0]   o_Regs,
    output logic                 o_Wr_Strobe,
    output logic [ADDR_W-1:0]    o_Wr_Addr,
    output logic                 o_Cmd_Err
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic                ai, ai_nxt;
    logic [7:0]          regs [DEPTH];
    logic                wr_en, tx_load, err_nxt;
    logic [7:0]          tx_nxt;
    logic                cs_sync, cs_rise;

    spi_cs_sync u_cs_sync (
        .clk     (i_Clk),
        .rst_n   (i_Rst_L),
        .cs_n    (i_SPI_CS_n),
        .cs_sync (cs_sync),
        .cs_rise (cs_rise)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= S_CMD;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        ai_nxt    = ai;
        wr_en     = 1'b0;
        tx_load   = 1'b0;
        tx_nxt    = o_TX_Byte;
        err_nxt   = 1'b0;
        if (i_RX_DV) begin
            unique case (state)
                S_CMD: begin
                    if (i_RX_Byte[CMD_RSVD_BIT]) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IGN;
                    end else begin
                        addr_nxt = i_RX_Byte[ADDR_W-1:0];
                        ai_nxt   = i_RX_Byte[CMD_AI_BIT];
                        if (i_RX_Byte[CMD_W_BIT]) begin
                            state_nxt = S_WR;
                        end else begin
                            tx_load   = 1'b1;
                            tx_nxt    = regs[addr_nxt];
                            state_nxt = S_RD;
                        end
                    end
                end
                S_WR: begin
                    wr_en = 1'b1;
                    if (ai) addr_nxt = addr + ADDR_W'(1);
                end
                S_RD: begin
                    if (ai) addr_nxt = addr + ADDR_W'(1);
                    tx_load = 1'b1;
                    tx_nxt  = regs[addr_nxt];
                end
                default: ;
            endcase
        end
        // End of transaction wins over a same-cycle read load; a write still lands.
        if (cs_rise) begin
            state_nxt = S_CMD;
            tx_load   = 1'b1;
            tx_nxt    = IDLE_BYTE;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            addr        <= '0;
            ai          <= 1'b0;
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= 8'h00;
            o_Wr_Strobe <= 1'b0;
            o_Wr_Addr   <= '0;
            o_Cmd_Err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            addr        <= addr_nxt;
            ai          <= ai_nxt;
            o_TX_DV     <= tx_load;
            o_TX_Byte   <= tx_nxt;
            o_Wr_Strobe <= wr_en;
            o_Cmd_Err   <= err_nxt;
            if (wr_en) begin
                regs[addr] <= i_RX_Byte;
                o_Wr_Addr  <= addr;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_Regs[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: drives received-byte pulses and chip select
// directly and checks registered outputs against hand-computed values.
module tb_spi_reg_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               rx_dv = 1'b0;
    logic [7:0]         rx_byte = 8'h00;
    logic               cs_n = 1'b1;
    logic               tx_dv;
    logic [7:0]         tx_byte;
    logic [8*DEPTH-1:0] regs;
    logic               wr_strobe;
    logic [ADDR_W-1:0]  wr_addr;
    logic               cmd_err;

    int n_tests = 0;
    int n_fail  = 0;

    spi_reg_ctrl #(.ADDR_W(ADDR_W), .IDLE_BYTE(8'hA5)) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_RX_DV     (rx_dv),
        .i_RX_Byte   (rx_byte),
        .i_SPI_CS_n  (cs_n),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .o_Regs      (regs),
        .o_Wr_Strobe (wr_strobe),
        .o_Wr_Addr   (wr_addr),
        .o_Cmd_Err   (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int n);
        return regs[8*n +: 8];
    endfunction

    // One received byte; returns at the negedge after the capturing posedge.
    task automatic send(input logic [7:0] b);
        repeat (3) @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic cs_start();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_end(input string tag);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_tx_dv_early"}, tx_dv, 1'b0);
        @(negedge clk);
        chk({tag, "_tx_dv"}, tx_dv, 1'b1);
        chk({tag, "_idle"}, tx_byte, 8'hA5);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_tx_dv", tx_dv, 1'b0);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_err", cmd_err, 1'b0);
        chk("rst_reg0", reg_at(0), 8'h00);
        rst_n = 1'b1;

        // Write burst with auto-increment from address 2
        cs_start();
        send(8'hC2); chk("wb_cmd_nostrobe", wr_strobe, 1'b0);
        send(8'h11); chk("wb_strobe0", wr_strobe, 1'b1); chk("wb_addr0", wr_addr, 2);
        send(8'h22); chk("wb_strobe1", wr_strobe, 1'b1); chk("wb_addr1", wr_addr, 3);
        send(8'h33); chk("wb_strobe2", wr_strobe, 1'b1); chk("wb_addr2", wr_addr, 4);
        cs_end("wb");
        chk("wb_reg2", reg_at(2), 8'h11);
        chk("wb_reg3", reg_at(3), 8'h22);
        chk("wb_reg4", reg_at(4), 8'h33);

        // Read with auto-increment
        cs_start();
        send(8'h42); chk("rd_dv0", tx_dv, 1'b1); chk("rd_b0", tx_byte, 8'h11);
        send(8'hFF); chk("rd_dv1", tx_dv, 1'b1); chk("rd_b1", tx_byte, 8'h22);
        send(8'hFF); chk("rd_b2", tx_byte, 8'h33);
        send(8'hFF); chk("rd_b3", tx_byte, 8'h00);
        chk("rd_nostrobe", wr_strobe, 1'b0);
        cs_end("rd");

        // Address wrap 15 -> 0
        cs_start();
        send(8'hCF);
        send(8'hAA); chk("wr_addr15", wr_addr, 15);
        send(8'hBB); chk("wr_addr0", wr_addr, 0);
        cs_end("wrap");
        chk("wrap_reg15", reg_at(15), 8'hAA);
        chk("wrap_reg0", reg_at(0), 8'hBB);

        // Fixed address, no auto-increment
        cs_start();
        send(8'h81);
        send(8'h5A); chk("fix_addr_a", wr_addr, 1);
        send(8'h6B); chk("fix_addr_b", wr_addr, 1); chk("fix_strobe_b", wr_strobe, 1'b1);
        cs_end("fix");
        chk("fix_reg1", reg_at(1), 8'h6B);
        chk("fix_reg2", reg_at(2), 8'h11);

        // Illegal command: reserved bit set
        cs_start();
        send(8'hA3); chk("ill_err", cmd_err, 1'b1); chk("ill_strobe0", wr_strobe, 1'b0);
        send(8'h55); chk("ill_err_once", cmd_err, 1'b0); chk("ill_strobe1", wr_strobe, 1'b0);
        cs_end("ill");
        chk("ill_reg3", reg_at(3), 8'h22);
        chk("ill_reg5", reg_at(5), 8'h00);
        // Next transaction decodes normally: fixed-address read of reg3
        cs_start();
        send(8'h03); chk("post_ill_rd0", tx_byte, 8'h22); chk("post_ill_dv", tx_dv, 1'b1);
        send(8'h00); chk("post_ill_rd1", tx_byte, 8'h22);
        cs_end("post_ill");

        // Byte arrives in the same cycle as the CS-rise pulse during a write
        cs_start();
        send(8'h87);
        send(8'h12); chk("sim_first", reg_at(7), 8'h12);
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = 8'h77;
        @(negedge clk);
        rx_dv   = 1'b0;
        chk("sim_strobe", wr_strobe, 1'b1);
        chk("sim_tx_dv", tx_dv, 1'b1);
        chk("sim_idle", tx_byte, 8'hA5);
        chk("sim_reg7", reg_at(7), 8'h77);
        repeat (5) @(negedge clk);
        // The following byte must be treated as a fresh command
        cs_start();
        send(8'h07); chk("sim_next_rd", tx_byte, 8'h77);
        cs_end("sim_next");

        // Asynchronous reset mid-burst
        cs_start();
        send(8'hC0);
        send(8'h99); chk("mr_reg0_written", reg_at(0), 8'h99);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mr_reg0", reg_at(0), 8'h00);
        chk("mr_reg7", reg_at(7), 8'h00);
        chk("mr_tx_byte", tx_byte, 8'h00);
        chk("mr_tx_dv", tx_dv, 1'b0);
        chk("mr_strobe", wr_strobe, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // CS still low: remaining bytes form a new command stream
        send(8'h85);
        send(8'h44); chk("mr_new_addr", wr_addr, 5); chk("mr_new_strobe", wr_strobe, 1'b1);
        cs_end("mr");
        chk("mr_reg5", reg_at(5), 8'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
